// File: rtl/uart_pkg.sv
// Shared UART definitions: auto-baud FSM encoding and measurement constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } ab_state_t;

  localparam int unsigned MIN_DVSR = 16;
  localparam int unsigned AB_EDGES = 5;
  localparam int unsigned AB_SHIFT = 3;
  localparam int unsigned AB_ROUND = 4;
  localparam int unsigned EDGE_W   = 3;

endpackage

// File: rtl/sync_fe.sv
// Two-flop synchronizer followed by a registered falling-edge strobe.
// Flops reset to 1 so an idle-high line never produces a spurious edge.
module sync_fe (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fe
);

  logic s1;
  logic s2;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_q <= 1'b1;
      fe   <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_q <= s2;
      fe   <= s2_q & ~s2;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud generator divisor owner: manual writes and 0x55 auto-baud measurement,
// each new divisor announced with a one-cycle bg_clr restart strobe.
module baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned         bbits    = 16,
  parameter logic [bbits-1:0]    DVSR_RST = 16'd5208
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             ab_start,
  input  logic             man_we,
  input  logic [bbits-1:0] man_dvsr,
  output logic [bbits-1:0] dvsr,
  output logic             bg_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = bbits + 3;
  localparam int unsigned SW = bbits + 4;

  ab_state_t           state;
  ab_state_t           state_nxt;
  logic                fe;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [EDGE_W-1:0]   ecnt;
  logic [EDGE_W-1:0]   ecnt_nxt;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       q;
  logic                q_ok;
  logic                last_edge;
  logic                timeout;
  logic [bbits-1:0]    dvsr_nxt;
  logic                bg_clr_nxt;
  logic                done_nxt;
  logic                err_nxt;

  sync_fe u_sync_fe (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .fe  (fe)
  );

  // cnt lags the true cycle count by one, so N = cnt + 1 on the closing edge
  always_comb begin
    sum       = SW'(cnt) + SW'(1) + SW'(AB_ROUND);
    q         = sum >> AB_SHIFT;
    q_ok      = (q >= SW'(MIN_DVSR)) && (q <= SW'({bbits{1'b1}}));
    last_edge = (state == MEASURE) && fe && (ecnt == EDGE_W'(AB_EDGES - 2));
    timeout   = (state == MEASURE) && !last_edge && (cnt == {CW{1'b1}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ab_start) state_nxt = ARM;
      ARM:     if (fe) state_nxt = MEASURE;
      MEASURE: if (last_edge || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dvsr_nxt   = dvsr;
    bg_clr_nxt = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    cnt_nxt    = cnt;
    ecnt_nxt   = ecnt;
    case (state)
      IDLE: begin
        if (man_we) begin
          dvsr_nxt   = man_dvsr;
          bg_clr_nxt = 1'b1;
        end
      end
      ARM: begin
        if (fe) begin
          cnt_nxt  = '0;
          ecnt_nxt = '0;
        end
      end
      MEASURE: begin
        cnt_nxt = cnt + CW'(1);
        if (fe) ecnt_nxt = ecnt + EDGE_W'(1);
        if (last_edge) begin
          if (q_ok) begin
            dvsr_nxt   = q[bbits-1:0];
            done_nxt   = 1'b1;
            bg_clr_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (timeout) begin
          err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ecnt   <= '0;
      dvsr   <= DVSR_RST;
      bg_clr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      ecnt   <= ecnt_nxt;
      dvsr   <= dvsr_nxt;
      bg_clr <= bg_clr_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      busy   <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl: a default 16-bit instance plus an 8-bit
// instance used for the timeout and upper-range cases.
module tb_baud_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        rx = 1'b1;
  logic        ab_start = 1'b0;
  logic        man_we = 1'b0;
  logic [15:0] man_dvsr = '0;
  logic [15:0] dvsr;
  logic        bg_clr, busy, done, err;

  logic        s_rx = 1'b1;
  logic        s_ab_start = 1'b0;
  logic        s_man_we = 1'b0;
  logic [7:0]  s_man_dvsr = '0;
  logic [7:0]  s_dvsr;
  logic        s_bg_clr, s_busy, s_done, s_err;

  logic        sel = 1'b0;
  logic        v_done, v_err, v_bg, v_busy;
  logic [31:0] v_dvsr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  baud_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .ab_start (ab_start),
    .man_we   (man_we),
    .man_dvsr (man_dvsr),
    .dvsr     (dvsr),
    .bg_clr   (bg_clr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  baud_ctrl #(.bbits(8), .DVSR_RST(8'd100)) u_small (
    .clk      (clk),
    .rst      (rst),
    .rx       (s_rx),
    .ab_start (s_ab_start),
    .man_we   (s_man_we),
    .man_dvsr (s_man_dvsr),
    .dvsr     (s_dvsr),
    .bg_clr   (s_bg_clr),
    .busy     (s_busy),
    .done     (s_done),
    .err      (s_err)
  );

  always_comb begin
    v_done = sel ? s_done   : done;
    v_err  = sel ? s_err    : err;
    v_bg   = sel ? s_bg_clr : bg_clr;
    v_busy = sel ? s_busy   : busy;
    v_dvsr = sel ? 32'(s_dvsr) : 32'(dvsr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input logic v);
    if (sel) s_rx = v;
    else     rx   = v;
  endtask

  task automatic start_ab();
    if (sel) s_ab_start = 1'b1;
    else     ab_start   = 1'b1;
    tick(1);
    s_ab_start = 1'b0;
    ab_start   = 1'b0;
    check("busy_rise", 32'(v_busy), 32'(1));
  endtask

  // Drives one 0x55 frame; even-indexed bits last pa cycles, odd ones pb.
  task automatic ab_run(input string tag, input int pa, input int pb,
                        input bit exp_ok, input int exp_dvsr);
    bit seen;
    seen = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      set_rx(i[0]);
      tick((i % 2 == 0) ? pa : pb);
    end
    set_rx(1'b0);
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1);
      if (v_done || v_err) seen = 1'b1;
    end
    check({tag, "_seen"},  32'(seen),   32'(1));
    check({tag, "_done"},  32'(v_done), 32'(exp_ok));
    check({tag, "_err"},   32'(v_err),  32'(!exp_ok));
    check({tag, "_bgclr"}, 32'(v_bg),   32'(exp_ok));
    check({tag, "_busy"},  32'(v_busy), 32'(0));
    check({tag, "_dvsr"},  v_dvsr,      32'(exp_dvsr));
    tick(1);
    check({tag, "_pulse"}, 32'({v_done, v_err, v_bg}), 32'(0));
    tick(pa);
    set_rx(1'b1);
    tick(pa + 4);
  endtask

  initial begin
    bit seen;
    bit bgs;
    int cyc;

    #1 rst = 1'b1;
    #2;
    check("rst_dvsr",   32'(dvsr),   32'(5208));
    check("rst_flags",  32'({bg_clr, busy, done, err}), 32'(0));
    check("rst_s_dvsr", 32'(s_dvsr), 32'(100));
    tick(2);
    rst = 1'b0;
    bgs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      bgs = bgs | bg_clr;
    end
    check("no_bgclr_after_rst", 32'(bgs), 32'(0));

    man_dvsr = 16'd434;
    man_we   = 1'b1;
    tick(1);
    man_we   = 1'b0;
    check("man_dvsr",  32'(dvsr),   32'(434));
    check("man_bgclr", 32'(bg_clr), 32'(1));
    tick(1);
    check("man_bgclr_end", 32'(bg_clr), 32'(0));

    start_ab();
    man_dvsr = 16'd999;
    man_we   = 1'b1;
    tick(1);
    man_we   = 1'b0;
    check("busy_we_dvsr",  32'(dvsr),   32'(434));
    check("busy_we_bgclr", 32'(bg_clr), 32'(0));
    check("busy_hold",     32'(busy),   32'(1));
    ab_run("ab104", 104, 104, 1'b1, 104);

    start_ab();
    ab_run("ab103p5", 103, 104, 1'b1, 104);
    start_ab();
    ab_run("fast10", 10, 10, 1'b0, 104);
    start_ab();
    ab_run("min15", 15, 15, 1'b0, 104);
    start_ab();
    ab_run("min16", 16, 16, 1'b1, 16);

    man_dvsr = 16'd777;
    man_we   = 1'b1;
    ab_start = 1'b1;
    tick(1);
    man_we   = 1'b0;
    ab_start = 1'b0;
    check("combo_dvsr",  32'(dvsr),   32'(777));
    check("combo_bgclr", 32'(bg_clr), 32'(1));
    check("combo_busy",  32'(busy),   32'(1));
    ab_run("combo50", 50, 50, 1'b1, 50);

    sel = 1'b1;
    tick(1);
    start_ab();
    tick(2);
    s_rx = 1'b0;
    tick(5);
    s_rx = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      tick(1);
      cyc = i + 1;
      if (s_err) seen = 1'b1;
    end
    check("to_seen",  32'(seen),  32'(1));
    check("to_late",  32'(cyc >= 2000), 32'(1));
    check("to_done",  32'(s_done), 32'(0));
    check("to_busy",  32'(s_busy), 32'(0));
    check("to_dvsr",  32'(s_dvsr), 32'(100));
    tick(2);
    start_ab();
    ab_run("max255", 255, 255, 1'b1, 255);
    start_ab();
    ab_run("over256", 256, 256, 1'b0, 255);

    sel = 1'b0;
    tick(1);
    start_ab();
    tick(3);
    for (int i = 0; i < 7; i++) begin
      rx = i[0];
      tick(20);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_dvsr",  32'(dvsr), 32'(5208));
    check("midrst_flags", 32'({bg_clr, busy, done, err}), 32'(0));
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    start_ab();
    ab_run("post_rst20", 20, 20, 1'b1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baud_ctrl.md
# baud_ctrl

Run-time controller for the UART baud generator. It owns the `dvsr` divisor that drives the baud generator, which produces `bd_tick` and the 16× `os_tick`. The divisor is set either by a direct host write or by auto-baud measurement of a 0x55 sync character on the receive line. Each new divisor is published with a one-cycle `bg_clr` strobe so the generator's timers restart in phase with the new rate.

## Interface
Parameters:
- `bbits`, 16, divisor width; must match the baud generator.
- `DVSR_RST`, 16'd5208, divisor value after reset (50 MHz / 9600 baud).

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  raw UART receive line, asynchronous; idles high.
- `ab_start`  in  1  single-cycle request to run auto-baud.
- `man_we`  in  1  single-cycle manual divisor write.
- `man_dvsr`  in  `bbits`  manual divisor value.
- `dvsr`  out  `bbits`  current divisor, to the baud generator.
- `bg_clr`  out  1  one-cycle restart strobe, ORed into the baud generator's `rst`.
- `busy`  out  1  high while auto-baud is armed or measuring.
- `done`  out  1  one-cycle pulse on successful auto-baud.
- `err`  out  1  one-cycle pulse on a failed auto-baud.

## Operation
- **rx conditioning**
  - Two-flop synchronizer on `rx`, then a registered falling-edge detector.
  - Output is a one-cycle strobe `fe`.
- **States: IDLE, ARM, MEASURE.**
- **IDLE**
  - `man_we` loads `dvsr <= man_dvsr` and pulses `bg_clr`. There is no range check on manual writes.
  - `ab_start` goes to ARM.
  - If `man_we` and `ab_start` are high together: the write takes effect, then the block enters ARM.
- **ARM**
  - Waits for the first `fe`, which is the start-bit edge of 0x55.
  - On that `fe`: clear the measurement counter and go to MEASURE.
  - There is no timeout in ARM. The host aborts by asserting `rst`.
- **MEASURE**
  - Counter `N` has width `bbits+3` and counts clock cycles since the first `fe`.
  - An edge counter counts further `fe` strobes.
  - 0x55 framed LSB-first gives falling edges at bit times 0, 2, 4, 6 and 8. The 5th edge overall (4th in MEASURE) therefore closes an 8-bit-period window: N = cycles between 1st and 5th `fe`.
  - On the 5th `fe`, compute `q = (N + 4) >> 3`, rounded to nearest, then:
    - if `q >= 16` and `q <= 2^bbits - 1`: set `dvsr <= q`, pulse `done` and `bg_clr`, return to IDLE;
    - otherwise: keep `dvsr` unchanged, pulse `err`, return to IDLE.
  - If N reaches all-ones before the 5th edge: pulse `err`, return to IDLE, keep `dvsr`.
- **Ignored inputs**
  - `man_we` and `ab_start` are ignored while `busy`.
- **Arithmetic**
  - `N + 4` is computed at `bbits+4` bits so it cannot wrap.
  - The minimum of 16 guarantees `dvsr >> 4 >= 1` for the oversampling timer.

## Timing
- **Reset values**
  - `dvsr = DVSR_RST`; `bg_clr`, `busy`, `done`, `err` = 0.
  - State is IDLE; synchronizer flops are 1 (line idle).
- **Reset mid-measurement:** immediate return to IDLE with reset values; any partial measurement is discarded.
- **Input latency**
  - `rx` falling to `fe` = 3 cycles.
  - The delay is identical for every edge, so it cancels in N.
- **Manual write:** `dvsr` and `bg_clr` appear the cycle after `man_we`.
- **Auto-baud result**
  - `dvsr`, `done` and `bg_clr` register together, one cycle after the 5th `fe`.
  - `busy` deasserts in that same cycle.
- **`busy`:** rises the cycle after `ab_start`.
- **Output pulses:** `done`, `err` and `bg_clr` are exactly one cycle wide and fully registered. `done` and `err` are mutually exclusive.

## Structure
- **Shared package `uart_pkg`**
  - State encoding: IDLE, ARM, MEASURE.
  - `MIN_DVSR = 16`.
  - `AB_EDGES = 5`.
  - `AB_SHIFT = 3`.
  - `AB_ROUND = 4`.
- **Sub-module `sync_fe`**
  - Two-flop synchronizer plus falling-edge strobe.
  - Reused later by the receiver.
- **Top level:** FSM, counters and divisor register live in `baud_ctrl`.

## Test plan
- **Reset values:** assert `rst` mid-cycle → `dvsr = 5208`, all strobes 0 asynchronously. After release, no `bg_clr` until a write.
- **Manual write:** `man_we` with `man_dvsr = 434` → next cycle `dvsr = 434`, `bg_clr` high for 1 cycle. A second `man_we` while `busy` leaves `dvsr` unchanged.
- **Auto-baud, 104 clk/bit:** `ab_start`, then drive 0x55 at 104 clk/bit → N = 832, `dvsr = 104`, `done` and `bg_clr` 1 cycle, `busy` low. Repeat with 103.5 clk/bit average jitter → `dvsr = 104` (rounding).
- **Too fast:** auto-baud at 10 clk/bit → N = 80, q = 10 → `err` pulse, `dvsr` unchanged.
- **Timeout:** `ab_start`, one falling edge, then hold `rx` high → `err` after 2^19−1 cycles (`bbits = 16`), state IDLE, `dvsr` unchanged.
- **Reset mid-measurement:** assert `rst` after 3 edges in MEASURE → immediate IDLE, `busy = 0`, `dvsr = 5208`. A new `ab_start` plus a full 0x55 at 20 clk/bit → `dvsr = 20`.
